// File: rtl/sc_reco_pkg.sv
// Shared types and helpers for the sequential (de)correlator family.
//   sc_side_t : selects which stream owns the deferred 1s.
//   sc_cnt_w  : width of a 0..depth saturating counter.
package sc_reco_pkg;

  typedef enum logic {SIDE_X = 1'b0, SIDE_Y = 1'b1} sc_side_t;

  function automatic int sc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sc_sat_updown_cnt.sv
// Saturating up/down counter, range 0..MAX.
//   clk, rst_n : clock and synchronous active-low reset (clears to 0)
//   inc, dec   : step requests. An inc at MAX and a dec at 0 are ignored,
//                so the count never wraps.
//   cnt        : current count
//   is_zero    : cnt == 0
//   is_max     : cnt == MAX
module sc_sat_updown_cnt #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         is_zero,
  output logic         is_max
);

  logic [W-1:0] r_cnt;

  assign cnt     = r_cnt;
  assign is_zero = (r_cnt == '0);
  assign is_max  = (r_cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (inc && !is_max)     r_cnt <= r_cnt + W'(1);
    else if (dec && !is_zero)    r_cnt <= r_cnt - W'(1);
  end

endmodule

// File: rtl/seq_desync_d.sv
// Sequential desynchronizer: pushes the SCC of the pair (x, y) toward -1.
// A coincident 1 on both streams is split: one stream's 1 is deferred into a
// bounded store (up to DEPTH bits) and released on a later coincident-0
// cycle, so each stream keeps its ones-count up to the bits still held.
//   clk, rst_n   : clock, synchronous active-low reset
//   in_valid     : x/y valid this cycle; state holds when low
//   x, y         : input bitstreams
//   flush        : also release on x!=y cycles where the owning stream is 0
//   x_d_r, y_d_r : registered desynchronized streams (1-cycle latency)
//   out_valid_r  : registered in_valid
//   empty        : no deferred bits held
module seq_desync_d
  import sc_reco_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic x,
  input  logic y,
  input  logic flush,
  output logic x_d_r,
  output logic y_d_r,
  output logic out_valid_r,
  output logic empty
);

  localparam int CW = sc_cnt_w(DEPTH);

  sc_side_t    r_side, r_alt;
  sc_side_t    w_side_nx, w_alt_nx;
  logic        w_inc, w_dec, w_zero, w_max;
  logic        w_xo, w_yo;
  logic [CW-1:0] w_cnt;

  sc_sat_updown_cnt #(.MAX(DEPTH), .W(CW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (w_inc),
    .dec     (w_dec),
    .cnt     (w_cnt),
    .is_zero (w_zero),
    .is_max  (w_max)
  );

  assign empty = w_zero;

  always_comb begin
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    w_side_nx = r_side;
    w_alt_nx  = r_alt;
    w_xo      = x;
    w_yo      = y;
    if (!in_valid) begin
      w_xo = 1'b0;
      w_yo = 1'b0;
    end else if (x && y) begin
      if (w_zero) begin
        // New deferral from empty: alt picks the owner, then flips for fairness.
        w_side_nx = r_alt;
        w_alt_nx  = (r_alt == SIDE_X) ? SIDE_Y : SIDE_X;
        w_inc     = 1'b1;
        if (r_alt == SIDE_X) w_xo = 1'b0;
        else                 w_yo = 1'b0;
      end else if (!w_max) begin
        w_inc = 1'b1;
        if (r_side == SIDE_X) w_xo = 1'b0;
        else                  w_yo = 1'b0;
      end
      // Saturated: pass 1,1 through unchanged.
    end else if (!x && !y) begin
      if (!w_zero) begin
        w_dec = 1'b1;
        if (r_side == SIDE_X) w_xo = 1'b1;
        else                  w_yo = 1'b1;
      end
    end else if (flush && !w_zero) begin
      // Draining on a split cycle costs one 1,1 overlap.
      if (r_side == SIDE_X && !x) begin
        w_xo  = 1'b1;
        w_dec = 1'b1;
      end else if (r_side == SIDE_Y && !y) begin
        w_yo  = 1'b1;
        w_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_side      <= SIDE_X;
      r_alt       <= SIDE_X;
      x_d_r       <= 1'b0;
      y_d_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      r_side      <= w_side_nx;
      r_alt       <= w_alt_nx;
      x_d_r       <= w_xo;
      y_d_r       <= w_yo;
      out_valid_r <= in_valid;
    end
  end

endmodule

// File: tb/tb_seq_desync_d.sv
// Directed vector table over DEPTH=1/2/4 instances sharing one stimulus,
// followed by a long anti-clustered correlated stream on the DEPTH=4 copy.
module tb_seq_desync_d;

  logic clk = 1'b0;
  logic rst_n, vld, x, y, fl;
  logic [2:0] xo, yo, ov, em;

  always #5 clk = ~clk;

  seq_desync_d #(.DEPTH(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(vld), .x(x), .y(y),
    .flush(fl), .x_d_r(xo[0]), .y_d_r(yo[0]), .out_valid_r(ov[0]), .empty(em[0]));
  seq_desync_d #(.DEPTH(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(vld), .x(x), .y(y),
    .flush(fl), .x_d_r(xo[1]), .y_d_r(yo[1]), .out_valid_r(ov[1]), .empty(em[1]));
  seq_desync_d #(.DEPTH(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(vld), .x(x), .y(y),
    .flush(fl), .x_d_r(xo[2]), .y_d_r(yo[2]), .out_valid_r(ov[2]), .empty(em[2]));

  typedef struct {
    string nm;
    int    sel;
    logic  r, v, x, y, f;
    logic  ex, ey, eov, eem;
  } vec_t;

  vec_t tab[$];
  int nvec = 0;
  int nmis = 0;

  task automatic add(input string nm, input int sel,
                     input logic r, input logic v, input logic xi, input logic yi, input logic f,
                     input logic ex, input logic ey, input logic eov, input logic eem);
    vec_t t;
    t.nm = nm; t.sel = sel; t.r = r; t.v = v; t.x = xi; t.y = yi; t.f = f;
    t.ex = ex; t.ey = ey; t.eov = eov; t.eem = eem;
    tab.push_back(t);
  endtask

  task automatic check(input string nm, input logic ok, input int got, input int want);
    nvec++;
    if (!ok) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int in_x, in_y, out_x, out_y, both, bad, n, s;
    logic b;
    real px, py, pxy, d, scc;

    rst_n = 1'b0; vld = 1'b1; x = 1'b1; y = 1'b1; fl = 1'b0;

    //   name      sel r v x y f   ex ey ov em
    add("rst0",    0, 0,1,1,1,0,  0, 0, 0, 1);
    add("rst1",    0, 0,1,1,1,0,  0, 0, 0, 1);
    add("d1_11a",  0, 1,1,1,1,0,  0, 1, 1, 0);   // alt=X -> X defers
    add("d1_00a",  0, 1,1,0,0,0,  1, 0, 1, 1);
    add("d1_11b",  0, 1,1,1,1,0,  1, 0, 1, 0);   // alt=Y now
    add("d1_00b",  0, 1,1,0,0,0,  0, 1, 1, 1);
    add("d1_11c",  0, 1,1,1,1,0,  0, 1, 1, 0);
    add("d1_sat",  0, 1,1,1,1,0,  1, 1, 1, 0);   // DEPTH=1 already full
    add("d1_rel",  0, 1,1,0,0,0,  1, 0, 1, 1);
    // DEPTH=2 saturation
    add("s_rst",   1, 0,1,1,1,0,  0, 0, 0, 1);
    add("s_11a",   1, 1,1,1,1,0,  0, 1, 1, 0);
    add("s_11b",   1, 1,1,1,1,0,  0, 1, 1, 0);
    add("s_11c",   1, 1,1,1,1,0,  1, 1, 1, 0);
    add("s_11d",   1, 1,1,1,1,0,  1, 1, 1, 0);
    add("s_00a",   1, 1,1,0,0,0,  1, 0, 1, 0);
    add("s_00b",   1, 1,1,0,0,0,  1, 0, 1, 1);
    add("s_00c",   1, 1,1,0,0,0,  0, 0, 1, 1);
    // DEPTH=2 flush
    add("f_rst",   1, 0,1,1,1,0,  0, 0, 0, 1);
    add("f_11a",   1, 1,1,1,1,0,  0, 1, 1, 0);
    add("f_11b",   1, 1,1,1,1,0,  0, 1, 1, 0);
    add("f_01f",   1, 1,1,0,1,1,  1, 1, 1, 0);   // drain costs an overlap
    add("f_10f",   1, 1,1,1,0,1,  1, 0, 1, 0);   // owner input is 1: pass
    add("f_01nf",  1, 1,1,0,1,0,  0, 1, 1, 0);   // no flush: pass, hold
    add("f_00",    1, 1,1,0,0,0,  1, 0, 1, 1);
    add("f_01e",   1, 1,1,0,1,1,  0, 1, 1, 1);   // flush when empty: pass
    // in_valid gap
    add("g_rst",   1, 0,1,1,1,0,  0, 0, 0, 1);
    add("g_11",    1, 1,1,1,1,0,  0, 1, 1, 0);
    add("g_gap0",  1, 1,0,1,1,0,  0, 0, 0, 0);
    add("g_gap1",  1, 1,0,1,1,0,  0, 0, 0, 0);
    add("g_gap2",  1, 1,0,1,1,0,  0, 0, 0, 0);
    add("g_00",    1, 1,1,0,0,0,  1, 0, 1, 1);

    for (int i = 0; i < tab.size(); i++) begin
      rst_n = tab[i].r; vld = tab[i].v; x = tab[i].x; y = tab[i].y; fl = tab[i].f;
      @(posedge clk); #1;
      s = tab[i].sel;
      nvec++;
      if ({xo[s], yo[s], ov[s], em[s]} !== {tab[i].ex, tab[i].ey, tab[i].eov, tab[i].eem}) begin
        nmis++;
        $display("FAIL %s: x/y/ov/empty got %b%b%b%b want %b%b%b%b", tab[i].nm,
                 xo[s], yo[s], ov[s], em[s], tab[i].ex, tab[i].ey, tab[i].eov, tab[i].eem);
      end
    end

    // Long fully correlated stream on DEPTH=4. Bits come in complementary
    // pairs (01 or 10) so runs never exceed 2 and the store never saturates.
    rst_n = 1'b0; vld = 1'b1; x = 1'b0; y = 1'b0; fl = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_x = 0; in_y = 0; out_x = 0; out_y = 0; both = 0; bad = 0; n = 10000; b = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) b = logic'($urandom_range(0, 1));
      else            b = ~b;
      x = b; y = b; fl = (i >= n - 64);
      in_x += int'(x); in_y += int'(y);
      @(posedge clk); #1;
      out_x += int'(xo[2]); out_y += int'(yo[2]);
      both  += int'(xo[2] & yo[2]);
      if (in_x - out_x < 0 || in_x - out_x > 4 || in_y - out_y < 0 || in_y - out_y > 4)
        bad++;
    end
    check("rand_deferred_bound", bad == 0, bad, 0);

    px  = real'(out_x) / n;
    py  = real'(out_y) / n;
    pxy = real'(both) / n;
    d   = pxy - px * py;
    if (d > 0.0) scc = d / (((px < py) ? px : py) - px * py);
    else         scc = d / (px * py - (((px + py - 1.0) > 0.0) ? (px + py - 1.0) : 0.0));
    check("rand_scc_x1000", scc < -0.9, int'(scc * 1000.0), -900);

    // Drain remaining deferred bits with 0,0, bounded.
    fl = 1'b0; x = 1'b0; y = 1'b0;
    for (int i = 0; i < 8 && !em[2]; i++) begin
      @(posedge clk); #1;
      out_x += int'(xo[2]); out_y += int'(yo[2]);
    end
    check("rand_drain_empty", em[2] === 1'b1, int'(em[2]), 1);
    check("rand_ones_x", out_x == in_x, out_x, in_x);
    check("rand_ones_y", out_y == in_y, out_y, in_y);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/seq_desync_d.md
Name: seq_desync_d

Overview:
- Sequential desynchronizer (anti-correlator) for stochastic bitstream pairs.
- Drives SCC of two streams toward -1 while preserving each stream's ones-count, up to a bounded number of deferred bits.
- It is the inverse-direction companion to the team's sequential recorrelator and sits before SC subtract and min-style gates that need negatively correlated operands.
- Coincident 1s are split: one 1 is deferred into a bounded store and released on a later coincident-0 cycle.

Parameters:
- DEPTH, 1, maximum number of deferred 1s held (save-counter saturation value); legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset: synchronous, active-low (sampled on the clk rising edge).
- in_valid  input  1  x/y carry a valid bit this cycle; when 0, all state holds.
- x  input  1  stochastic stream X bit.
- y  input  1  stochastic stream Y bit.
- flush  input  1  drain mode: release deferred 1s on any cycle where the holding stream's input is 0.
- x_d_r  output  1  registered desynchronized X.
- y_d_r  output  1  registered desynchronized Y.
- out_valid_r  output  1  registered copy of in_valid.
- empty  output  1  combinational, 1 when cnt==0 (no deferred bits).

Behaviour:
- Reset (rst_n==0 at a clk edge): cnt=0, side=SIDE_X, alt=SIDE_X, x_d_r=0, y_d_r=0, out_valid_r=0. Reset mid-stream discards deferred 1s; the loss is accepted.
- State:
  - cnt: width $clog2(DEPTH+1), range 0..DEPTH.
  - side: which stream owns the deferred 1s.
  - alt: fairness toggle that chooses the side when a new deferral starts from empty.
- Latency: 1 cycle. x_d_r/y_d_r/out_valid_r reflect the inputs of the previous edge.
- in_valid==0: cnt/side/alt hold; next x_d_r=y_d_r=0; out_valid_r=0.
- in_valid==1, per-cycle rules (next outputs xo, yo; default xo=x, yo=y, state holds):
  - x=1,y=1, cnt==0: side<=alt; alt<=~alt; cnt<=1; the stream selected by alt outputs 0, the other outputs 1.
  - x=1,y=1, 0<cnt<DEPTH: stream 'side' outputs 0; cnt<=cnt+1.
  - x=1,y=1, cnt==DEPTH: saturated; pass through 1,1; state holds.
  - x=0,y=0, cnt>0: stream 'side' outputs 1, other 0; cnt<=cnt-1.
  - x=0,y=0, cnt==0: pass through 0,0.
  - x!=y, flush==0: pass through; state holds.
  - x!=y, flush==1, cnt>0, side's input==0: side outputs 1, producing 1,1 (accepted cost of draining); cnt<=cnt-1.
  - x!=y, flush==1, side's input==1 or cnt==0: pass through.
- side changes only when cnt==0 at a coincident-1 cycle. It never changes while cnt>0.
- Reaching cnt==0 by decrement leaves side stale (don't-care); alt is unaffected by releases.
- No arithmetic wraps: increment is gated by cnt<DEPTH and decrement by cnt>0.
- Invariant: over any window, ones(x_d_r) + (cnt if side==X) equals ones(x) delayed by one cycle. The same holds for Y.

Decomposition:
- Shared package sc_reco_pkg holds:
  - typedef enum logic {SIDE_X, SIDE_Y} sc_side_t;
  - function sc_cnt_w(DEPTH) returning $clog2(DEPTH+1).
- Recorrelator variants import the same package.
- One natural sub-module: sc_sat_updown_cnt (parameter MAX; inputs inc, dec; outputs cnt, is_zero, is_max). It is reusable by the recorrelator family.
- Next-state and output logic stay in one always_comb.

Test Plan:
- Reset: hold rst_n=0 two edges with x=y=1, in_valid=1 → x_d_r=0, y_d_r=0, out_valid_r=0, empty=1. Release; next edge gives cnt=1, side=X.
- DEPTH=1, in_valid=1, x,y pairs (1,1),(0,0),(1,1),(0,0):
  - outputs (one edge later) (0,1),(1,0),(1,0),(0,1), since alt toggles;
  - cnt sequence 1,0,1,0; output overlap count 0.
- Saturation, DEPTH=2: (1,1)×4 → outputs (0,1),(0,1),(1,1),(1,1); cnt 1,2,2,2. Then (0,0)×3 → (1,0),(1,0),(0,0); empty=1 after the second.
- Flush, DEPTH=2: (1,1),(1,1) so cnt=2, side=X. Then (0,1) with flush=1 → (1,1), cnt=1. Then (0,1) with flush=0 → (0,1), cnt holds at 1.
- in_valid gap: cnt=1, then in_valid=0 for 3 cycles with x=y=1 → outputs 0,0, out_valid_r=0, cnt stays 1. Resume with (0,0) → (1,0).
- Random: 10k-bit Bernoulli streams px=0.5, py=0.5 with SCC≈+1, DEPTH=4, flush asserted for the last 64 cycles:
  - output ones-count per stream matches input ±cnt_final;
  - measured output SCC < -0.9.
